// File: rtl/pe_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// pe_ctrl_pkg
// Shared types and constants for the 25-tap convolution PE sequencer.
//   state_t    : sequencer FSM states
//   K          : convolution window edge length (5x5 window)
//   PE_LAT_DEF : default PE input-to-result latency in cycles
//   RES_W      : PE result width
//   sat_int8() : clamps a signed RES_W value into the int8 range
// ---------------------------------------------------------------------------
package pe_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    DRAIN,
    DONE
  } state_t;

  localparam int K          = 5;
  localparam int PE_LAT_DEF = 3;
  localparam int RES_W      = 24;
  localparam int INT8_MAX   = 127;
  localparam int INT8_MIN   = -128;

  localparam logic signed [RES_W-1:0] RES_INT8_MAX = RES_W'(INT8_MAX);
  localparam logic signed [RES_W-1:0] RES_INT8_MIN = RES_W'(INT8_MIN);

  // Values already inside [-128,127] keep their low byte, which is their
  // two's-complement int8 encoding.
  function automatic logic [7:0] sat_int8(input logic signed [RES_W-1:0] v);
    logic [7:0] r;
    if (v > RES_INT8_MAX) begin
      r = 8'h7F;
    end else if (v < RES_INT8_MIN) begin
      r = 8'h80;
    end else begin
      r = v[7:0];
    end
    return r;
  endfunction

endpackage

// File: rtl/pe_requant.sv
// ---------------------------------------------------------------------------
// pe_requant
// Combinational requantizer for one PE result.
// Ports:
//   din   in  RES_W  signed PE result
//   shift in  4      arithmetic right shift amount (rounds toward -inf)
//   relu  in  1      1 = negative values become 0
//   dout  out 8      saturated signed int8
// ---------------------------------------------------------------------------
module pe_requant
  import pe_ctrl_pkg::*;
(
  input  logic [RES_W-1:0] din,
  input  logic [3:0]       shift,
  input  logic             relu,
  output logic [7:0]       dout
);

  logic signed [RES_W-1:0] shifted;
  logic signed [RES_W-1:0] clamped;

  // Shift first so ReLU and saturation see the rescaled value; the sign bit
  // of the shifted value decides ReLU since >>> preserves sign.
  always_comb begin
    shifted = $signed(din) >>> shift;
    clamped = (relu && shifted[RES_W-1]) ? '0 : shifted;
    dout    = sat_int8(clamped);
  end

endmodule

// File: rtl/pe_conv_ctrl.sv
// ---------------------------------------------------------------------------
// pe_conv_ctrl
// Sequencer for the 25-tap convolution PE: walks a stride-1 5x5 window over
// the configured plane, keeps the PE enabled until its pipeline drains, and
// requantizes each result to int8 with a row-major output address.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   start                    one-cycle launch pulse, honoured only when idle
//   cfg_in_w, cfg_in_h       input plane size, sampled on accepted start
//   cfg_shift, cfg_relu      requantization settings, sampled on accepted start
//   busy, done, err          status: busy start..done, done pulse, bad config
//   win_req, win_row/col     window request and its origin
//   win_ack                  window data present on PE inputs this cycle
//   conv_en                  PE enable
//   pe_result                PE output, valid PE_LAT cycles after an issue
//   out_valid/addr/data      requantized result stream, no backpressure
// ---------------------------------------------------------------------------
module pe_conv_ctrl
  import pe_ctrl_pkg::*;
#(
  parameter int PE_LAT = PE_LAT_DEF,
  parameter int DIM_W  = 8,
  parameter int ADDR_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [DIM_W-1:0]  cfg_in_w,
  input  logic [DIM_W-1:0]  cfg_in_h,
  input  logic [3:0]        cfg_shift,
  input  logic              cfg_relu,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic              win_req,
  output logic [DIM_W-1:0]  win_row,
  output logic [DIM_W-1:0]  win_col,
  input  logic              win_ack,
  output logic              conv_en,
  input  logic [RES_W-1:0]  pe_result,
  output logic              out_valid,
  output logic [ADDR_W-1:0] out_addr,
  output logic [7:0]        out_data
);

  state_t state, state_nxt;

  logic [DIM_W-1:0]  col_last;
  logic [DIM_W-1:0]  row_last;
  logic [DIM_W-1:0]  row;
  logic [DIM_W-1:0]  col;
  logic [3:0]        shift_q;
  logic              relu_q;
  logic              err_q;
  logic [PE_LAT-1:0] vld;
  logic [ADDR_W-1:0] addr_cnt;
  logic              out_valid_q;
  logic [ADDR_W-1:0] out_addr_q;
  logic [7:0]        out_data_q;
  logic [7:0]        req_data;

  logic cfg_ok;
  logic start_acc;
  logic issue;
  logic last_col;
  logic last_win;

  assign cfg_ok    = (cfg_in_w >= DIM_W'(K)) && (cfg_in_h >= DIM_W'(K));
  assign start_acc = start && (state == IDLE);
  assign issue     = (state == ISSUE) && win_ack;
  assign last_col  = (col == col_last);
  assign last_win  = last_col && (row == row_last);

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state and the state-decoded control outputs. DRAIN waits for every
  // in-flight slot so the PE pipeline is never cleared under real data.
  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    win_req   = 1'b0;
    conv_en   = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_nxt = cfg_ok ? ISSUE : DONE;
        end
      end
      ISSUE: begin
        busy    = 1'b1;
        win_req = 1'b1;
        conv_en = 1'b1;
        if (issue && last_win) begin
          state_nxt = DRAIN;
        end
      end
      DRAIN: begin
        busy    = 1'b1;
        conv_en = 1'b1;
        if (vld == '0) begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        busy      = 1'b1;
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Configuration latch and window origin counters. The stored limits are
  // the last valid origin (in - K), so the wrap test is a plain compare.
  // Counters return to 0 after the final window so the next plane starts
  // clean even without a reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      col_last <= '0;
      row_last <= '0;
      shift_q  <= '0;
      relu_q   <= 1'b0;
      err_q    <= 1'b0;
      row      <= '0;
      col      <= '0;
    end else if (start_acc) begin
      col_last <= cfg_in_w - DIM_W'(K);
      row_last <= cfg_in_h - DIM_W'(K);
      shift_q  <= cfg_shift;
      relu_q   <= cfg_relu;
      err_q    <= !cfg_ok;
      row      <= '0;
      col      <= '0;
    end else if (issue) begin
      if (last_win) begin
        row <= '0;
        col <= '0;
      end else if (last_col) begin
        row <= row + 1'b1;
        col <= '0;
      end else begin
        col <= col + 1'b1;
      end
    end
  end

  // Valid pipe mirroring the PE stages: a bit enters on each accepted window
  // and reaches the top exactly when pe_result belongs to that window.
  // Bubbles (ack low) shift in zeros.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld <= '0;
    end else begin
      vld <= (vld << 1) | PE_LAT'(issue);
    end
  end

  pe_requant u_requant (
    .din   (pe_result),
    .shift (shift_q),
    .relu  (relu_q),
    .dout  (req_data)
  );

  // Output registers. Results arrive in issue order, so the output address
  // is just a running count of emitted results.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_addr_q  <= '0;
      out_data_q  <= '0;
      addr_cnt    <= '0;
    end else begin
      out_valid_q <= vld[PE_LAT-1];
      if (start_acc) begin
        addr_cnt <= '0;
      end else if (vld[PE_LAT-1]) begin
        out_data_q <= req_data;
        out_addr_q <= addr_cnt;
        addr_cnt   <= addr_cnt + 1'b1;
      end
    end
  end

  assign err       = err_q;
  assign win_row   = row;
  assign win_col   = col;
  assign out_valid = out_valid_q;
  assign out_addr  = out_addr_q;
  assign out_data  = out_data_q;

endmodule

// File: doc/pe_conv_ctrl.md
Name: pe_conv_ctrl

Overview:
Sequencer for the 25-tap convolution PE (5x5 window, 24-bit result, 3-stage pipeline that clears while its enable is low).
- Walks a stride-1 5x5 window over a configured input plane and requests each window from the window fetch unit.
- Holds the PE enable continuously from first issue until the pipeline drains.
- Tracks which pipeline slots carry real data, then requantizes each PE result (shift, optional ReLU, int8 saturate) and emits it with a linear output address.

Parameters:
PE_LAT, 3, PE input-to-result latency in cycles; length of the valid shift register
DIM_W, 8, width of image dimension and window coordinate fields
ADDR_W, 16, width of the output address

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
start  in  1  one-cycle pulse; launches a plane; ignored unless idle
cfg_in_w  in  DIM_W  input width; sampled on accepted start
cfg_in_h  in  DIM_W  input height; sampled on accepted start
cfg_shift  in  4  arithmetic right shift for requantization; sampled on start
cfg_relu  in  1  1 = clamp negative results to 0; sampled on start
busy  out  1  high from accepted start until the done cycle, inclusive
done  out  1  one-cycle completion pulse
err  out  1  set with done when the configuration is invalid; cleared on next accepted start
win_req  out  1  requests the window at win_row/win_col
win_row  out  DIM_W  window origin row
win_col  out  DIM_W  window origin column
win_ack  in  1  window data is on the PE image inputs this cycle
conv_en  out  1  PE enable
pe_result  in  24  PE result
out_valid  out  1  out_data/out_addr valid this cycle; no backpressure
out_addr  out  ADDR_W  linear output index, row-major
out_data  out  8  requantized signed int8

Behaviour:
Reset:
- On rst, state goes to IDLE. All outputs go to 0 and the valid pipe is cleared.
- Reset mid-plane discards every in-flight result; no out_valid or done follows.

Output size: out_w = in_w-4, out_h = in_h-4. If in_w<5 or in_h<5, the configuration is invalid.

IDLE:
- On start with a valid configuration, latch the configuration, clear counters and err, and go to ISSUE.
- On start with an invalid configuration, go to DONE with err=1.

ISSUE:
- conv_en=1 and win_req=1, with win_row/win_col set to the current origin.
- Each cycle with win_req&&win_ack is an issue: vld[0]<=1, otherwise vld[0]<=0. vld shifts by one each cycle.
- Column increments per issue. At out_w-1 it wraps to 0 and the row increments.
- The issue of (out_h-1, out_w-1) moves to DRAIN, and win_req drops the next cycle.
- When win_ack is low, conv_en stays 1 (a bubble); the bubble is not marked valid.

DRAIN:
- conv_en=1 and win_req=0.
- When vld is all-zero, go to DONE.

DONE:
- done=1 for one cycle, conv_en=0, then go to IDLE.

Result capture:
- When vld[PE_LAT-1]=1, pe_result is valid (issue cycle t gives a result in cycle t+3).
- The requantized value is registered, so out_valid is high in cycle t+4.
- out_addr starts at 0 and increments per out_valid. Results stay in issue order, so no multiplier is needed.

Requantization:
- Shift: signed pe_result >>> cfg_shift (rounds toward -inf).
- ReLU: if cfg_relu=1, negative values become 0.
- Saturate to [-128,127].

Other rules:
- start while busy is ignored; the latched configuration does not change.
- DRAIN waits on all in-flight slots, so conv_en is never low while a valid slot is in flight.

Decomposition:
- Package pe_ctrl_pkg: state enum {IDLE, ISSUE, DRAIN, DONE}, K=5, PE_LAT default, result width 24, int8 limits.
- Sub-module pe_requant: combinational shift, ReLU and saturate, 24-bit in to 8-bit out.
- Top level holds the FSM, coordinate counters, valid pipe, address counter and output registers.

Test Plan:
1. in 5x5, shift=1, relu=0, win_ack held 1, model pe_result=300 at t+3 -> one win_req at (0,0); out_data=127 (150 saturated), out_addr=0 at t+4; done the cycle after vld empties; busy low after done.
2. in_w=6, in_h=7 -> windows (0,0),(0,1),(1,0),(1,1),(2,0),(2,1) in order; six out_valid with out_addr 0..5 contiguous; exactly one done.
3. 6x6 plane with win_ack low for 3 cycles after the 2nd issue -> conv_en stays 1 throughout; exactly 4 out_valid, each at its issue+4; no out_valid on bubbles.
4. Requantization:
   - pe_result=-200, relu=1 -> out_data=0.
   - relu=0, shift=0 -> 0x80.
   - pe_result=-5, shift=1 -> 0xFD (-3).
   - pe_result=0x7FFFFF, shift=15 -> 127.
5. cfg_in_w=4 -> done and err on the cycle after start; win_req and conv_en never assert. A following valid start clears err.
6. rst during ISSUE of a 6x6 plane -> next cycle busy=0, conv_en=0, out_valid=0; no stale out_valid later. A new start completes a normal 4-output run. A start pulse while busy is ignored.
